// File: rtl/fp_commit_seq_if.sv
// Commit bus from the FP commit sequencer into the fp CSR block.
// The live fcsr value comes back to the sequencer for FFLAGS/FRM read-modify-write.
interface fp_commit_seq_if;
  logic        valid;
  logic        csren;
  logic [11:0] csrindex;
  logic [63:0] csrdata;
  logic        fflagen;
  logic [4:0]  fflag;
  logic [63:0] fcsr;

  modport master (
    output valid, csren, csrindex, csrdata, fflagen, fflag,
    input  fcsr
  );

  modport slave (
    input  valid, csren, csrindex, csrdata, fflagen, fflag,
    output fcsr
  );
endinterface

// File: rtl/fp_commit_seq.sv
// In-order FP commit sequencer: holds pending FP ops in a ring, gathers their writeback flags
// and retires the head as a registered single-cycle commit into the fp CSR block.
module fp_commit_seq #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned TagW = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                srstn_i,
  input  logic                flush_i,
  input  logic                alloc_valid_i,
  output logic                alloc_ready_o,
  output logic [TagW-1:0]     alloc_tag_o,
  input  logic                alloc_iscsr_i,
  input  logic [11:0]         alloc_csridx_i,
  input  logic [63:0]         alloc_csrdat_i,
  input  logic                wb_valid_i,
  input  logic [TagW-1:0]     wb_tag_i,
  input  logic [4:0]          wb_fflag_i,
  fp_commit_seq_if.master     commit_if
);

  localparam int unsigned CntW      = TagW + 1;
  localparam logic [11:0] IdxFflags = 12'h001;
  localparam logic [11:0] IdxFrm    = 12'h002;
  localparam logic [11:0] IdxFcsr   = 12'h003;

  // Only the low byte of CSR data can ever reach FCSR, so only that byte is stored.
  logic [DEPTH-1:0] busy_q, busy_d, done_q, done_d, iscsr_q, iscsr_d;
  logic [11:0]      csridx_q [DEPTH];
  logic [11:0]      csridx_d [DEPTH];
  logic [7:0]       csrdat_q [DEPTH];
  logic [7:0]       csrdat_d [DEPTH];
  logic [4:0]       eflag_q  [DEPTH];
  logic [4:0]       eflag_d  [DEPTH];

  logic [TagW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             valid_q, valid_d, prev_valid_q, prev_valid_d;
  logic             csren_q, csren_d, fflagen_q, fflagen_d;
  logic [11:0]      csrindex_q, csrindex_d;
  logic [63:0]      csrdata_q, csrdata_d;
  logic [4:0]       fflag_q, fflag_d;

  logic             hazard, retire, do_alloc;
  logic             unused_hi;

  assign unused_hi     = ^{alloc_csrdat_i[63:8], commit_if.fcsr[63:8]};
  assign alloc_ready_o = (cnt_q != CntW'(DEPTH));
  assign alloc_tag_o   = tail_q;
  assign do_alloc      = alloc_valid_i & alloc_ready_o;

  // fcsr feedback lags a commit by up to two cycles; CSR read-modify-write waits it out.
  assign hazard = valid_q | prev_valid_q;
  assign retire = busy_q[head_q] & done_q[head_q] & (~iscsr_q[head_q] | ~hazard);

  assign commit_if.valid    = valid_q;
  assign commit_if.csren    = csren_q;
  assign commit_if.csrindex = csrindex_q;
  assign commit_if.csrdata  = csrdata_q;
  assign commit_if.fflagen  = fflagen_q;
  assign commit_if.fflag    = fflag_q;

  always_comb begin
    busy_d       = busy_q;
    done_d       = done_q;
    iscsr_d      = iscsr_q;
    csridx_d     = csridx_q;
    csrdat_d     = csrdat_q;
    eflag_d      = eflag_q;
    head_d       = head_q;
    tail_d       = tail_q;
    cnt_d        = cnt_q + CntW'(do_alloc) - CntW'(retire);
    prev_valid_d = valid_q;
    valid_d      = 1'b0;
    csren_d      = 1'b0;
    csrindex_d   = '0;
    csrdata_d    = '0;
    fflagen_d    = 1'b0;
    fflag_d      = '0;

    if (retire) begin
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
      head_d         = head_q + TagW'(1);
      valid_d        = 1'b1;
      if (iscsr_q[head_q]) begin
        case (csridx_q[head_q])
          IdxFflags: begin
            csren_d    = 1'b1;
            csrindex_d = IdxFcsr;
            csrdata_d  = {56'b0, commit_if.fcsr[7:5], csrdat_q[head_q][4:0]};
          end
          IdxFrm: begin
            csren_d    = 1'b1;
            csrindex_d = IdxFcsr;
            csrdata_d  = {56'b0, csrdat_q[head_q][2:0], commit_if.fcsr[4:0]};
          end
          IdxFcsr: begin
            csren_d    = 1'b1;
            csrindex_d = IdxFcsr;
            csrdata_d  = {56'b0, csrdat_q[head_q]};
          end
          default: ;
        endcase
      end else begin
        fflagen_d = |eflag_q[head_q];
        fflag_d   = eflag_q[head_q];
      end
    end

    if (wb_valid_i && busy_q[wb_tag_i] && !iscsr_q[wb_tag_i] && !done_q[wb_tag_i]) begin
      done_d[wb_tag_i]  = 1'b1;
      eflag_d[wb_tag_i] = wb_fflag_i;
    end

    if (do_alloc) begin
      busy_d[tail_q]   = 1'b1;
      done_d[tail_q]   = alloc_iscsr_i;
      iscsr_d[tail_q]  = alloc_iscsr_i;
      csridx_d[tail_q] = alloc_csridx_i;
      csrdat_d[tail_q] = alloc_csrdat_i[7:0];
      eflag_d[tail_q]  = '0;
      tail_d           = tail_q + TagW'(1);
    end

    if (flush_i) begin
      busy_d     = '0;
      done_d     = '0;
      head_d     = '0;
      tail_d     = '0;
      cnt_d      = '0;
      valid_d    = 1'b0;
      csren_d    = 1'b0;
      csrindex_d = '0;
      csrdata_d  = '0;
      fflagen_d  = 1'b0;
      fflag_d    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srstn_i) begin
      busy_q       <= '0;
      done_q       <= '0;
      iscsr_q      <= '0;
      csridx_q     <= '{default: '0};
      csrdat_q     <= '{default: '0};
      eflag_q      <= '{default: '0};
      head_q       <= '0;
      tail_q       <= '0;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      prev_valid_q <= 1'b0;
      csren_q      <= 1'b0;
      csrindex_q   <= '0;
      csrdata_q    <= '0;
      fflagen_q    <= 1'b0;
      fflag_q      <= '0;
    end else begin
      busy_q       <= busy_d;
      done_q       <= done_d;
      iscsr_q      <= iscsr_d;
      csridx_q     <= csridx_d;
      csrdat_q     <= csrdat_d;
      eflag_q      <= eflag_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      prev_valid_q <= prev_valid_d;
      csren_q      <= csren_d;
      csrindex_q   <= csrindex_d;
      csrdata_q    <= csrdata_d;
      fflagen_q    <= fflagen_d;
      fflag_q      <= fflag_d;
    end
  end

endmodule
